// File: rtl/ram_timing_model_pkg.sv
// Shared types for the latency-accurate RAM model: bus word, RAM status codes,
// latched operation kind and default build parameters.
package ram_timing_model_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } ram_op_t;

  localparam int RAM_LAT_DEFAULT   = 4;
  localparam int RAM_DEPTH_DEFAULT = 4096;

  // Address width of a word index for a given depth (never below one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_timing_model_if.sv
// RAM request port between the memory controller (master) and the RAM model
// (slave).
interface ram_timing_model_if;

  logic                              ramREN;
  logic                              ramWEN;
  ram_timing_model_pkg::word_t       ramaddr;
  ram_timing_model_pkg::word_t       ramstore;
  ram_timing_model_pkg::word_t       ramload;
  ram_timing_model_pkg::ramstate_t   ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/ram_word_array.sv
// DEPTH x 32 storage: one combinational read port, one synchronous write port.
// Contents are not reset.
module ram_word_array
  import ram_timing_model_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH_DEFAULT,
  parameter int AW    = idx_width(DEPTH)
) (
  input  logic          CLK,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  word_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output word_t         rdata_o
);

  word_t mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ram_timing_model.sv
// Single-port word RAM that stalls each request for LAT cycles (BUSY) and then
// completes it in exactly one ACCESS cycle.
module ram_timing_model
  import ram_timing_model_pkg::*;
#(
  parameter int LAT   = RAM_LAT_DEFAULT,
  parameter int DEPTH = RAM_DEPTH_DEFAULT
) (
  input  logic               CLK,
  input  logic               RST,
  ram_timing_model_if.slave  ram
);

  localparam int        AW       = idx_width(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  if (LAT < 1 || LAT > 15) begin : g_lat_range
    $error("ram_timing_model: LAT=%0d is outside 1..15", LAT);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  fsm_t          state_q, state_d;
  logic [3:0]    cnt_q,   cnt_d;
  logic [AW-1:0] idx_q,   idx_d;
  ram_op_t       op_q,    op_d;

  logic          req;
  logic          both;
  logic          oor;
  logic          err;
  logic          changed;
  ram_op_t       cur_op;
  logic [AW-1:0] cur_idx;
  logic          mem_we;
  word_t         mem_rdata;
  logic          unused_addr_lsb;

  assign req     = ram.ramREN || ram.ramWEN;
  assign both    = ram.ramREN && ram.ramWEN;
  assign oor     = req && ({2'b00, ram.ramaddr[31:2]} >= 32'(DEPTH));
  assign err     = both || oor;
  assign cur_op  = ram.ramWEN ? OP_WR : OP_RD;
  assign cur_idx = ram.ramaddr[AW+1:2];
  // An out-of-range request raises err first, so comparing AW index bits suffices.
  assign changed = (cur_idx != idx_q) || (cur_op != op_q);
  assign unused_addr_lsb = ^ram.ramaddr[1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      op_q    <= OP_RD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    op_d    = op_q;
    if (err) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            idx_d   = cur_idx;
            op_d    = cur_op;
            cnt_d   = CNT_LOAD;
            state_d = (LAT == 1) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req) begin
            state_d = S_IDLE;
          end else if (changed) begin
            // A new address or op restarts the full latency from this cycle.
            idx_d = cur_idx;
            op_d  = cur_op;
            cnt_d = CNT_LOAD;
          end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ram.ramstate = FREE;
    ram.ramload  = '0;
    mem_we       = 1'b0;
    if (err) begin
      ram.ramstate = ERROR;
    end else begin
      unique case (state_q)
        S_IDLE: ram.ramstate = req ? BUSY : FREE;
        S_WAIT: ram.ramstate = BUSY;
        S_DONE: begin
          ram.ramstate = ACCESS;
          if (op_q == OP_RD) begin
            ram.ramload = mem_rdata;
          end else begin
            // Reset in the completion cycle aborts the commit.
            mem_we = !RST;
          end
        end
        default: ram.ramstate = FREE;
      endcase
    end
  end

  ram_word_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .CLK     (CLK),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (ram.ramstore),
    .raddr_i (idx_q),
    .rdata_o (mem_rdata)
  );

endmodule
